icache_responder: RTL and testbench

- Direct-mapped instruction cache that answers the fetch stage's instruction requests.
- Each cycle it takes the fetch address and returns the instruction word combinationally on a hit.
- On a miss it asserts a stall toward fetch and refills the line from main memory over a burst handshake.
- Sits between the fetch stage and the main-memory port.

---
 rtl/icache_responder_pkg.sv | 19 +
 rtl/icache_tag_store.sv | 40 ++++
 rtl/icache_responder.sv | 137 +++++++++++++
 tb/tb_icache_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/icache_responder_pkg.sv
// Shared definitions for the instruction cache: FSM encodings, default address-field
// widths and the reset vector shared with fetch.
package icache_responder_pkg;

   typedef enum logic [1:0] {
      LOOKUP = 2'd0,
      FILL   = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int DEF_LINES          = 64;
   localparam int DEF_WORDS_PER_LINE = 4;
   localparam int DEF_OFFSET_BITS    = $clog2(DEF_WORDS_PER_LINE);
   localparam int DEF_INDEX_BITS     = $clog2(DEF_LINES);
   localparam int DEF_TAG_BITS       = 32 - 2 - DEF_OFFSET_BITS - DEF_INDEX_BITS;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC00000;

endpackage

// File: rtl/icache_tag_store.sv
// Valid/tag arrays for the direct-mapped instruction cache: lookup compare,
// invalidate-all on reset, per-line invalidate and tag write.
module icache_tag_store
   import icache_responder_pkg::*;
#(
   parameter int LINES = DEF_LINES,
   parameter int TB    = DEF_TAG_BITS,
   parameter int IB    = $clog2(LINES)
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic [IB-1:0] lookup_index,
   input  logic [TB-1:0] lookup_tag,
   output logic          hit,
   input  logic          clr_en,
   input  logic [IB-1:0] clr_index,
   input  logic          wr_en,
   input  logic [IB-1:0] wr_index,
   input  logic [TB-1:0] wr_tag
);

   logic [LINES-1:0] valid;
   logic [TB-1:0]    tag_mem [LINES];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         valid <= '0;
      end else begin
         if (clr_en) valid[clr_index] <= 1'b0;
         if (wr_en)  valid[wr_index]  <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en) tag_mem[wr_index] <= wr_tag;
   end

   assign hit = valid[lookup_index] && (tag_mem[lookup_index] == lookup_tag);

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache between fetch and main memory; hits answer
// combinationally, misses stall fetch while a line is burst-filled.
// Optional hit/miss statistics are built when ICACHE_STATS_EN is defined.
module icache_responder
   import icache_responder_pkg::*;
#(
   parameter int          LINES          = DEF_LINES,
   parameter int          WORDS_PER_LINE = DEF_WORDS_PER_LINE,
   parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] Instr_address_fIF,
   output logic [31:0] Instr1_2IF,
   output logic        STALL_2IF,
   output logic        Mem_Req,
   output logic [31:0] Mem_Addr,
   input  logic        Mem_Valid,
   input  logic [31:0] Mem_Data,
   output logic [31:0] Hit_Count,
   output logic [31:0] Miss_Count
);

   localparam int OB = $clog2(WORDS_PER_LINE);
   localparam int IB = $clog2(LINES);
   localparam int TB = 32 - 2 - OB - IB;
   localparam logic [OB-1:0] LAST_BEAT = OB'(WORDS_PER_LINE - 1);

   state_t        state;
   logic [OB-1:0] beat;
   logic [IB-1:0] fill_index;
   logic [TB-1:0] fill_tag;
   logic [31:0]   data_mem [LINES*WORDS_PER_LINE];

   logic [OB-1:0] addr_offset;
   logic [IB-1:0] addr_index;
   logic [TB-1:0] addr_tag;
   logic          tag_hit;
   logic          lookup_hit;
   logic          miss_start;
   logic          beat_wr;
   logic          last_beat;
   logic          unused_dbg;

   assign addr_offset = Instr_address_fIF[2 +: OB];
   assign addr_index  = Instr_address_fIF[2+OB +: IB];
   assign addr_tag    = Instr_address_fIF[31 -: TB];

   // Byte-lane bits are never used; the reset-vector compare only labels debug views.
   assign unused_dbg = ^{Instr_address_fIF[1:0], (Instr_address_fIF == RESET_PC)};

   assign lookup_hit = RESET && (state == LOOKUP) && tag_hit;
   assign miss_start = (state == LOOKUP) && !tag_hit;
   assign beat_wr    = (state == FILL) && Mem_Valid;
   assign last_beat  = beat_wr && (beat == LAST_BEAT);

   assign Instr1_2IF = lookup_hit ? data_mem[{addr_index, addr_offset}] : '0;
   assign STALL_2IF  = !lookup_hit;

   icache_tag_store #(
      .LINES (LINES),
      .TB    (TB),
      .IB    (IB)
   ) u_tag_store (
      .CLK          (CLK),
      .RESET        (RESET),
      .lookup_index (addr_index),
      .lookup_tag   (addr_tag),
      .hit          (tag_hit),
      .clr_en       (miss_start),
      .clr_index    (addr_index),
      .wr_en        (last_beat),
      .wr_index     (fill_index),
      .wr_tag       (fill_tag)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state      <= LOOKUP;
         Mem_Req    <= 1'b0;
         Mem_Addr   <= '0;
         beat       <= '0;
         fill_index <= '0;
         fill_tag   <= '0;
      end else begin
         case (state)
            LOOKUP: begin
               if (!tag_hit) begin
                  // Index/tag are latched so a fetch redirect cannot corrupt the fill.
                  Mem_Addr   <= {Instr_address_fIF[31:OB+2], {(OB+2){1'b0}}};
                  Mem_Req    <= 1'b1;
                  beat       <= '0;
                  fill_index <= addr_index;
                  fill_tag   <= addr_tag;
                  state      <= FILL;
               end
            end
            FILL: begin
               if (Mem_Valid) begin
                  beat <= beat + 1'b1;
                  if (beat == LAST_BEAT) begin
                     Mem_Req <= 1'b0;
                     state   <= DONE;
                  end
               end
            end
            DONE:    state <= LOOKUP;
            default: state <= LOOKUP;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (beat_wr) data_mem[{fill_index, beat}] <= Mem_Data;
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         Hit_Count  <= '0;
         Miss_Count <= '0;
      end else begin
         if (lookup_hit) Hit_Count  <= Hit_Count + 32'd1;
         if (miss_start) Miss_Count <= Miss_Count + 32'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET && miss_start)
         $display("icache_responder: miss addr=%h (reset_pc=%h)", Instr_address_fIF, RESET_PC);
   end
`else
   assign Hit_Count  = '0;
   assign Miss_Count = '0;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: fills, hits, conflicts, gapped beats,
// fetch redirect and reset mid-fill, checked against a queue of expected words.
module tb_icache_responder;

   logic        CLK;
   logic        RESET;
   logic [31:0] Instr_address_fIF;
   logic [31:0] Instr1_2IF;
   logic        STALL_2IF;
   logic        Mem_Req;
   logic [31:0] Mem_Addr;
   logic        Mem_Valid;
   logic [31:0] Mem_Data;
   logic [31:0] Hit_Count;
   logic [31:0] Miss_Count;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

`ifdef ICACHE_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   icache_responder dut (
      .CLK               (CLK),
      .RESET             (RESET),
      .Instr_address_fIF (Instr_address_fIF),
      .Instr1_2IF        (Instr1_2IF),
      .STALL_2IF         (STALL_2IF),
      .Mem_Req           (Mem_Req),
      .Mem_Addr          (Mem_Addr),
      .Mem_Valid         (Mem_Valid),
      .Mem_Data          (Mem_Data),
      .Hit_Count         (Hit_Count),
      .Miss_Count        (Miss_Count)
   );

   // Clock and reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Main-memory contents as seen by the bench
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a[31:16] == 16'hBFC0) return 32'h000000A0 + {30'd0, a[3:2]};
      return {a[31:2], 2'b00} ^ 32'h5EED0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_stats(input string tag, input logic [31:0] hits, input logic [31:0] misses);
      check({tag, "_hit_count"},  Hit_Count,  STATS_ON ? hits   : 32'd0);
      check({tag, "_miss_count"}, Miss_Count, STATS_ON ? misses : 32'd0);
   endtask

   // Reset is released just after a rising edge so the next task starts in LOOKUP.
   task automatic do_reset(input logic [31:0] addr);
      RESET = 1'b0;
      Instr_address_fIF = addr;
      repeat (2) @(negedge CLK);
      #1;
      check("rst_stall", {31'd0, STALL_2IF}, 32'd1);
      check("rst_instr", Instr1_2IF, 32'd0);
      check("rst_req", {31'd0, Mem_Req}, 32'd0);
      check("rst_addr", Mem_Addr, 32'd0);
      check_stats("rst", 32'd0, 32'd0);
      @(posedge CLK);
      #1 RESET = 1'b1;
   endtask

   // Miss on addr, then burst the line using pattern (LSB first, 1 = beat present).
   task automatic miss_fill(input logic [31:0] addr, input logic [15:0] pattern, input int plen,
                            input logic redir, input logic [31:0] raddr);
      logic [31:0] base;
      int nbeats;
      base = {addr[31:4], 4'h0};
      nbeats = 0;
      @(negedge CLK);
      Instr_address_fIF = addr;
      #1;
      check("miss_stall", {31'd0, STALL_2IF}, 32'd1);
      check("miss_instr", Instr1_2IF, 32'd0);
      for (int i = 0; i < plen && nbeats < 4; i++) begin
         @(negedge CLK);
         if (redir && nbeats == 2) Instr_address_fIF = raddr;
         Mem_Valid = pattern[i];
         Mem_Data = pattern[i] ? mem_word(base + 32'(4 * nbeats)) : 32'hFFFF_FFFF;
         #1;
         check("fill_req", {31'd0, Mem_Req}, 32'd1);
         check("fill_addr", Mem_Addr, base);
         check("fill_stall", {31'd0, STALL_2IF}, 32'd1);
         if (pattern[i]) begin
            exp_q.push_back(mem_word(base + 32'(4 * nbeats)));
            nbeats++;
         end
      end
      check("fill_beats", 32'(nbeats), 32'd4);
      @(negedge CLK);
      Mem_Valid = 1'b0;
      Mem_Data = 32'hFFFF_FFFF;
      #1;
      check("done_req", {31'd0, Mem_Req}, 32'd0);
      check("done_stall", {31'd0, STALL_2IF}, 32'd1);
   endtask

   // Read every word of a filled line, popping the expected words in order.
   task automatic read_line(input logic [31:0] base, input logic chk_stats);
      logic [31:0] exp;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         Instr_address_fIF = base + 32'(4 * i);
         #1;
         check("hit_stall", {31'd0, STALL_2IF}, 32'd0);
         check("hit_req", {31'd0, Mem_Req}, 32'd0);
         if (exp_q.size() == 0) begin
            check("hit_queue_empty", 32'd0, 32'd1);
         end else begin
            exp = exp_q.pop_front();
            check("hit_instr", Instr1_2IF, exp);
         end
         if (chk_stats) check_stats("stats_hits", 32'(i), 32'd1);
      end
   endtask

   initial begin
      Mem_Valid = 1'b0;
      Mem_Data = '0;
      Instr_address_fIF = 32'hBFC00000;

      // Cold miss at the reset vector, then the rest of the line hits.
      do_reset(32'hBFC00000);
      miss_fill(32'hBFC00000, 16'h000F, 4, 1'b0, 32'd0);
      read_line(32'hBFC00000, 1'b0);

      // Conflict on index 0 between two tags.
      miss_fill(32'h00000000, 16'h000F, 4, 1'b0, 32'd0);
      read_line(32'h00000000, 1'b0);
      miss_fill(32'h00000400, 16'h000F, 4, 1'b0, 32'd0);
      read_line(32'h00000400, 1'b0);
      miss_fill(32'h00000000, 16'h000F, 4, 1'b0, 32'd0);
      read_line(32'h00000000, 1'b0);

      // Gapped beats 1,0,0,1,1,0,1.
      miss_fill(32'h00000030, 16'b1011001, 7, 1'b0, 32'd0);
      read_line(32'h00000030, 1'b0);

      // Fetch redirect mid-fill: old line completes, new one then misses.
      do_reset(32'hBFC00000);
      miss_fill(32'hBFC00000, 16'h000F, 4, 1'b1, 32'h00000010);
      miss_fill(32'h00000010, 16'h000F, 4, 1'b0, 32'd0);
      read_line(32'hBFC00000, 1'b0);
      read_line(32'h00000010, 1'b0);

      // Reset during beat 2 with late beats arriving while reset is held.
      @(negedge CLK);
      Instr_address_fIF = 32'h00000020;
      for (int b = 0; b < 2; b++) begin
         @(negedge CLK);
         Mem_Valid = 1'b1;
         Mem_Data = mem_word(32'h00000020 + 32'(4 * b));
      end
      @(negedge CLK);
      Mem_Data = 32'hDEAD_BEEF;
      RESET = 1'b0;
      #1;
      check("midrst_req", {31'd0, Mem_Req}, 32'd0);
      check("midrst_stall", {31'd0, STALL_2IF}, 32'd1);
      check("midrst_instr", Instr1_2IF, 32'd0);
      do_reset(32'h00000020);
      miss_fill(32'h00000020, 16'h000F, 4, 1'b0, 32'd0);
      check_stats("stats_miss", 32'd0, 32'd1);
      read_line(32'h00000020, 1'b1);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
